// File: rtl/alu_pipe_pkg.sv
// rtl/alu_pipe_pkg.sv - shared command codes, status bit indices and FSM states for alu_pipe
package alu_pipe_pkg;

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_MUL = 4'b1010;

  localparam int ST_N = 3;
  localparam int ST_Z = 2;
  localparam int ST_C = 1;
  localparam int ST_V = 0;

  typedef enum logic {
    IDLE    = 1'b0,
    MUL_RUN = 1'b1
  } state_t;

  function automatic logic [3:0] make_status(input logic n, input logic z,
                                             input logic c, input logic v);
    logic [3:0] s;
    s       = '0;
    s[ST_N] = n;
    s[ST_Z] = z;
    s[ST_C] = c;
    s[ST_V] = v;
    return s;
  endfunction

endpackage

// File: rtl/alu_pipe_alu_comb.sv
// rtl/alu_pipe_alu_comb.sv - combinational single-cycle ALU ops and NZCV generation
module alu_comb
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       cmd,
  input  logic             carry_in,
  output logic [WIDTH-1:0] res,
  output logic [3:0]       status
);

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] opb;
  logic             is_sub;
  logic             cin;
  logic             c;
  logic             v;
  logic             known;

  // Subtraction is A + ~B + cin, so the carry out is directly "no borrow".
  always_comb begin
    is_sub = (cmd == CMD_SUB) || (cmd == CMD_SBC);
    opb    = is_sub ? ~b : b;
    if ((cmd == CMD_ADC) || (cmd == CMD_SBC)) begin
      cin = carry_in;
    end else begin
      cin = is_sub;
    end
    sum    = {1'b0, a} + {1'b0, opb} + (WIDTH+1)'(cin);
    res    = '0;
    c      = carry_in;
    v      = 1'b0;
    known  = 1'b1;
    case (cmd)
      CMD_MOV: res = b;
      CMD_MVN: res = ~b;
      CMD_AND: res = a & b;
      CMD_ORR: res = a | b;
      CMD_EOR: res = a ^ b;
      CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC: begin
        res = sum[WIDTH-1:0];
        c   = sum[WIDTH];
        v   = (a[WIDTH-1] == opb[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      default: known = 1'b0;
    endcase
    if (known) begin
      status = make_status(res[WIDTH-1], res == '0, c, v);
    end else begin
      status = '0;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - handshaked execute-stage ALU with registered NZCV and iterative multiply
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] val1,
  input  logic [WIDTH-1:0] val2,
  input  logic [3:0]       exec_cmd,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_res,
  output logic [3:0]       status,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] mcand, mcand_n;
  logic [WIDTH-1:0] mplier, mplier_n;
  logic [WIDTH-1:0] acc, acc_n;
  logic [WIDTH-1:0] step_acc;
  logic [WIDTH-1:0] comb_res, res_n;
  logic [3:0]       comb_status, status_n;
  logic             out_valid_n;
  logic             in_fire;
  logic             out_fire;
  logic             is_mul;

  alu_comb #(.WIDTH(WIDTH)) u_alu_comb (
    .a        (val1),
    .b        (val2),
    .cmd      (exec_cmd),
    .carry_in (carry_in),
    .res      (comb_res),
    .status   (comb_status)
  );

  assign in_ready = (state == IDLE) && (!out_valid || out_ready);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign is_mul   = MUL_EN && (exec_cmd == CMD_MUL);
  assign busy     = (state == MUL_RUN);
  assign step_acc = mplier[0] ? acc + mcand : acc;

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    mcand_n     = mcand;
    mplier_n    = mplier;
    acc_n       = acc;
    res_n       = alu_res;
    status_n    = status;
    out_valid_n = out_valid;
    case (state)
      IDLE: begin
        if (out_fire) out_valid_n = 1'b0;
        if (in_fire) begin
          if (is_mul) begin
            state_n  = MUL_RUN;
            cnt_n    = CW'(WIDTH);
            mcand_n  = val1;
            mplier_n = val2;
            acc_n    = '0;
          end else begin
            res_n       = comb_res;
            status_n    = comb_status;
            out_valid_n = 1'b1;
          end
        end
      end
      MUL_RUN: begin
        // out_valid is always low here: a MUL is only accepted once the old result is gone.
        acc_n    = step_acc;
        mcand_n  = mcand << 1;
        mplier_n = mplier >> 1;
        cnt_n    = cnt - 1'b1;
        if (cnt == CW'(1)) begin
          state_n     = IDLE;
          res_n       = step_acc;
          status_n    = make_status(step_acc[WIDTH-1], step_acc == '0, 1'b0, 1'b0);
          out_valid_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      alu_res   <= '0;
      status    <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      mcand     <= mcand_n;
      mplier    <= mplier_n;
      acc       <= acc_n;
      alu_res   <= res_n;
      status    <= status_n;
      out_valid <= out_valid_n;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - directed self-checking bench for alu_pipe at WIDTH=32 and WIDTH=8
module tb_alu_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, carry_in, busy;
  logic [31:0] val1, val2, alu_res;
  logic [3:0]  exec_cmd, status;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_carry_in, b_busy;
  logic [7:0]  b_val1, b_val2, b_alu_res;
  logic [3:0]  b_exec_cmd, b_status;

  int compared = 0;
  int mismatched = 0;
  int n_busy, n_rdy, n_ov;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(32), .MUL_EN(1'b1)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .val1(val1), .val2(val2), .exec_cmd(exec_cmd), .carry_in(carry_in),
    .out_valid(out_valid), .out_ready(out_ready), .alu_res(alu_res),
    .status(status), .busy(busy)
  );

  alu_pipe #(.WIDTH(8), .MUL_EN(1'b1)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .val1(b_val1), .val2(b_val2), .exec_cmd(b_exec_cmd), .carry_in(b_carry_in),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .alu_res(b_alu_res),
    .status(b_status), .busy(b_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b1; carry_in = 1'b0;
    val1 = '0; val2 = '0; exec_cmd = 4'b0000;
    b_in_valid = 1'b0; b_out_ready = 1'b1; b_carry_in = 1'b0;
    b_val1 = '0; b_val2 = '0; b_exec_cmd = 4'b0000;
    tick(); tick();
    rst = 1'b0;

    chk("reset_out_valid", out_valid, 0);
    chk("reset_alu_res", alu_res, 0);
    chk("reset_status", status, 0);
    chk("reset_busy", busy, 0);
    chk("reset_in_ready", in_ready, 1);

    // Back-to-back ADDs at one per cycle
    in_valid = 1'b1; exec_cmd = 4'b0010; val1 = -32'd12; val2 = 32'd20;
    tick();
    chk("add1_res", alu_res, 32'd8);
    chk("add1_status", status, 4'b0010);
    chk("add1_out_valid", out_valid, 1);
    chk("add1_in_ready", in_ready, 1);
    val1 = -32'd2147483647; val2 = -32'd2147483647;
    tick();
    chk("add2_res", alu_res, 32'd2);
    chk("add2_status", status, 4'b0011);
    val1 = 32'd10; val2 = -32'd21;
    tick();
    chk("add3_res", alu_res, 32'hFFFFFFF5);
    chk("add3_status", status, 4'b1000);
    val1 = -32'd10; val2 = 32'd10;
    tick();
    chk("add4_res", alu_res, 32'd0);
    chk("add4_status", status, 4'b0110);
    in_valid = 1'b0;
    tick();
    chk("drain_out_valid", out_valid, 0);

    // MUL 7 * -3
    in_valid = 1'b1; exec_cmd = 4'b1010; val1 = 32'd7; val2 = -32'd3;
    tick();
    in_valid = 1'b0; val1 = 32'd99; val2 = 32'd99;
    n_busy = 0; n_rdy = 0;
    while (busy && n_busy < 100) begin
      n_busy++;
      if (in_ready) n_rdy++;
      tick();
    end
    chk("mul_busy_cycles", n_busy, 32);
    chk("mul_in_ready_while_busy", n_rdy, 0);
    chk("mul_out_valid", out_valid, 1);
    chk("mul_res", alu_res, 32'hFFFFFFEB);
    chk("mul_status", status, 4'b1000);
    tick();
    chk("mul_drain", out_valid, 0);

    // MUL aborted by reset at cycle 10
    in_valid = 1'b1; exec_cmd = 4'b1010; val1 = 32'd7; val2 = -32'd3;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    chk("mulrst_busy_before", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mulrst_busy", busy, 0);
    chk("mulrst_in_ready", in_ready, 1);
    n_ov = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) n_ov++;
      tick();
    end
    chk("mulrst_no_output", n_ov, 0);
    chk("mulrst_res_cleared", alu_res, 0);

    // Backpressure on SUB 5-9
    out_ready = 1'b0;
    in_valid = 1'b1; exec_cmd = 4'b0100; val1 = 32'd5; val2 = 32'd9;
    tick();
    in_valid = 1'b0; val1 = 32'd1; val2 = 32'd1;
    n_rdy = 0; n_ov = 0;
    for (int i = 0; i < 5; i++) begin
      if (in_ready) n_rdy++;
      if (!out_valid || alu_res !== 32'hFFFFFFFC || status !== 4'b1000) n_ov++;
      tick();
    end
    chk("bp_in_ready_low", n_rdy, 0);
    chk("bp_hold_unstable", n_ov, 0);
    chk("bp_res", alu_res, 32'hFFFFFFFC);
    chk("bp_status", status, 4'b1000);
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", in_ready, 1);
    tick();
    chk("bp_transfer", out_valid, 0);
    chk("bp_after_in_ready", in_ready, 1);

    // WIDTH=8 boundary cases
    b_in_valid = 1'b1; b_exec_cmd = 4'b0010; b_val1 = 8'd127; b_val2 = 8'd1;
    tick();
    chk("w8_add_res", b_alu_res, 8'h80);
    chk("w8_add_status", b_status, 4'b1001);
    b_exec_cmd = 4'b0101; b_val1 = 8'd0; b_val2 = 8'd0; b_carry_in = 1'b0;
    tick();
    chk("w8_sbc_res", b_alu_res, 8'hFF);
    chk("w8_sbc_status", b_status, 4'b1000);
    b_exec_cmd = 4'b0110; b_val1 = 8'hF0; b_val2 = 8'h0F; b_carry_in = 1'b1;
    tick();
    chk("w8_and_res", b_alu_res, 8'h00);
    chk("w8_and_status", b_status, 4'b0110);
    b_exec_cmd = 4'b1111; b_val1 = 8'h12; b_val2 = 8'h34;
    tick();
    chk("w8_unknown_res", b_alu_res, 8'h00);
    chk("w8_unknown_status", b_status, 4'b0000);
    chk("w8_unknown_out_valid", b_out_valid, 1);
    b_in_valid = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
